mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// Shares one single-ported memory between IF-stage instruction fetch and MEM-stage load/store.
// Grants one requester at a time and drives a req/ack memory handshake with timeout.
// Returns read data with a one-cycle valid pulse.
// Produces per-stage stall signals consumed by the hazard unit (pcWrite/ifidWrite/stall).
// PARAMETERS
// ADDR_W        32  address width
// DATA_W        32  data width
// MAX_WAIT      15  cycles in grant state with mAck low before the access is abandoned
// STARVE_LIMIT  4   back-to-back MEM grants (IF pending) before IF is forced to win
// PORTS
// clk        in   1       clock; all state updates on rising edge
// rst        in   1       reset; synchronous, active-high
// ifReq      in   1       fetch request; held until ifValid
// ifAddr     in   ADDR_W  fetch address (PC)
// ifRdata    out  DATA_W  fetched instruction; valid when ifValid
// ifValid    out  1       one-cycle pulse: fetch done
// ifStall    out  1       ifReq & ~ifValid (combinational)
// memReq     in   1       load/store request; held until memValid
// memWe      in   1       1 = store, 0 = load
// memAddr    in   ADDR_W  data address (ALU result)
// memWdata   in   DATA_W  store data
// memRdata   out  DATA_W  load data; valid when memValid
// memValid   out  1       one-cycle pulse: data access done
// memStall   out  1       memReq & ~memValid (combinational)
// mReq       out  1       memory request; held until mAck or timeout
// mWe        out  1       memory write enable
// mAddr      out  ADDR_W  memory address
// mWdata     out  DATA_W  memory write data
// mRdata     in   DATA_W  memory read data; sampled when mAck=1
// mAck       in   1       memory completion
// busErr     out  1       one-cycle pulse with the valid of a timed-out access
// BEHAVIOUR
// - FSM states: IDLE, GNT_IF, GNT_MEM, RESP.
// - IDLE arbitration:
//   - memReq wins unless starveCnt==STARVE_LIMIT and ifReq=1, in which case IF wins.
//   - Else ifReq wins. Neither request: stay in IDLE.
// - On grant: register mAddr, mWe, mWdata from the winner (IF: mWe=0, mWdata=0); set mReq=1 next cycle.
// - GNT_x with mAck=1:
//   - Register rdata (mRdata for loads/fetches, 0 for stores); mReq=0; go to RESP.
// - GNT_x with mAck=0: waitCnt++.
// - Timeout: when waitCnt==MAX_WAIT, set mReq=0 and rdata=0, assert busErr in RESP, go to RESP.
// - RESP: pulse xValid for the granted requester only; all requests ignored this cycle; return to IDLE.
// - Latency: req in cycle 0, mAck in cycle 1 (earliest), xValid in cycle 2. Minimum 2 cycles; +1 per wait cycle.
// - starveCnt:
//   - Increments on a MEM grant while ifReq=1 (saturates at STARVE_LIMIT).
//   - Clears on an IF grant, or on a MEM grant with ifReq=0.
// - Requester drops req mid-grant: access still completes on the memory and xValid still pulses.
// - mAck outside GNT_x: ignored.
// - rst=1 at an edge: state=IDLE; waitCnt and starveCnt=0; mReq=0 from the following cycle.
//   - An in-flight access is abandoned and no xValid is issued.
// - Reset values: mReq, mWe, mAddr, mWdata, ifRdata, memRdata, ifValid, memValid, busErr all 0.
// - Stalls are combinational on the inputs.
// CONFIGURATION
// ARB_PERF_CNT_EN defined: adds outputs ifStallCycles[31:0] and memStallCycles[31:0].
//   - Each counts cycles its stall is high; saturates at 32'hFFFF_FFFF; cleared by rst.
// ARB_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// 1 IF only:
//   - Stimulus: ifReq=1, ifAddr=0x40 at c0; mAck=1, mRdata=0x8C220004 at c1.
//   - Response: mReq=1, mAddr=0x40 at c1; ifValid=1, ifRdata=0x8C220004 at c2; ifStall=0 from c2.
// 2 Simultaneous ifReq (0x44) and memReq load (0x100):
//   - MEM is granted first (mAddr=0x100); memValid comes before IF.
//   - IF is then granted with mAddr=0x44.
// 3 Starvation (STARVE_LIMIT=4):
//   - Stimulus: memReq and ifReq held high, 1-cycle ack.
//   - Response: exactly 4 MEM grants, then 1 IF grant, then MEM again.
// 4 Timeout:
//   - Stimulus: memReq load, mAck held 0.
//   - Response: mReq is high for 15 cycles then drops; memValid=1, busErr=1, memRdata=0 in the same cycle.
// 5 Reset mid-access:
//   - Stimulus: rst=1 during GNT_MEM.
//   - Response: mReq=0 next cycle; no memValid. After release, test 1 passes unchanged.
// 6 Store:
//   - Stimulus: memWe=1, memAddr=0x200, memWdata=0xDEADBEEF.
//   - Response: mWe=1, mAddr=0x200, mWdata=0xDEADBEEF; then memValid=1, memRdata=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req_i/if_addr_i            fetch request and PC, held until if_valid_o
//   if_rdata_o/if_valid_o         fetched word and its one-cycle done pulse
//   if_stall_o                    if_req_i & ~if_valid_o
//   mem_req_i/mem_we_i            load/store request, held until mem_valid_o
//   mem_addr_i/mem_wdata_i        data address and store data
//   mem_rdata_o/mem_valid_o       load data (0 for stores) and its done pulse
//   mem_stall_o                   mem_req_i & ~mem_valid_o
//   m_req_o/m_we_o/m_addr_o/m_wdata_o  memory request side, req held until ack or timeout
//   m_rdata_i/m_ack_i             memory read data and completion
//   bus_err_o                     pulses with the valid of a timed-out access
// Optional macro ARB_PERF_CNT_EN adds if_stall_cycles_o/mem_stall_cycles_o saturating stall counters.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_WAIT     = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   output logic              if_stall_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_valid_o,
   output logic              mem_stall_o,
   output logic              m_req_o,
   output logic              m_we_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   input  logic [DATA_W-1:0] m_rdata_i,
   input  logic              m_ack_i,
   output logic              bus_err_o
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       if_stall_cycles_o,
   output logic [31:0]       mem_stall_cycles_o
`endif
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, RESP} state_t;
   state_t            state_q, state_d;
   logic [WW-1:0]     wait_q, wait_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              m_req_q, m_req_d, m_we_q, m_we_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d, if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
   logic              if_valid_q, if_valid_d, mem_valid_q, mem_valid_d, bus_err_q, bus_err_d;
   logic              mem_win, done;
   logic [DATA_W-1:0] rdata;
   // IF overrides MEM only once MEM has won STARVE_LIMIT grants in a row while IF waited
   assign mem_win = mem_req_i & ~(if_req_i & (starve_q == SW'(STARVE_LIMIT)));
   // the wait count holds completed no-ack cycles, so the last allowed one is MAX_WAIT-1
   assign done    = m_ack_i | (wait_q == WW'(MAX_WAIT - 1));
   assign rdata   = (m_ack_i & ~m_we_q) ? m_rdata_i : '0;
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      starve_d    = starve_q;
      m_req_d     = m_req_q;
      m_we_d      = m_we_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      bus_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_win) begin
               state_d   = GNT_MEM;
               m_req_d   = 1'b1;
               m_we_d    = mem_we_i;
               m_addr_d  = mem_addr_i;
               m_wdata_d = mem_wdata_i;
               wait_d    = '0;
               starve_d  = !if_req_i ? '0 : (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
            end else if (if_req_i) begin
               state_d   = GNT_IF;
               m_req_d   = 1'b1;
               m_we_d    = 1'b0;
               m_addr_d  = if_addr_i;
               m_wdata_d = '0;
               wait_d    = '0;
               starve_d  = '0;
            end
         end
         GNT_IF, GNT_MEM: begin
            if (done) begin
               state_d     = RESP;
               m_req_d     = 1'b0;
               bus_err_d   = ~m_ack_i;
               if_valid_d  = (state_q == GNT_IF);
               mem_valid_d = (state_q == GNT_MEM);
               if_rdata_d  = (state_q == GNT_IF) ? rdata : if_rdata_q;
               mem_rdata_d = (state_q == GNT_MEM) ? rdata : mem_rdata_q;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         starve_q    <= '0;
         m_req_q     <= 1'b0;
         m_we_q      <= 1'b0;
         m_addr_q    <= '0;
         m_wdata_q   <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         starve_q    <= starve_d;
         m_req_q     <= m_req_d;
         m_we_q      <= m_we_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_valid_q  <= if_valid_d;
         mem_valid_q <= mem_valid_d;
         bus_err_q   <= bus_err_d;
      end
   end
   assign m_req_o     = m_req_q;
   assign m_we_o      = m_we_q;
   assign m_addr_o    = m_addr_q;
   assign m_wdata_o   = m_wdata_q;
   assign if_rdata_o  = if_rdata_q;
   assign mem_rdata_o = mem_rdata_q;
   assign if_valid_o  = if_valid_q;
   assign mem_valid_o = mem_valid_q;
   assign bus_err_o   = bus_err_q;
   assign if_stall_o  = if_req_i & ~if_valid_q;
   assign mem_stall_o = mem_req_i & ~mem_valid_q;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] if_cyc_q, mem_cyc_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         if_cyc_q  <= '0;
         mem_cyc_q <= '0;
      end else begin
         if (if_stall_o && ~&if_cyc_q) if_cyc_q <= if_cyc_q + 32'd1;
         if (mem_stall_o && ~&mem_cyc_q) mem_cyc_q <= mem_cyc_q + 32'd1;
      end
   end
   assign if_stall_cycles_o  = if_cyc_q;
   assign mem_stall_cycles_o = mem_cyc_q;
`endif
endmodule
